// File: rtl/seg_scan_ctrl.sv
// Scan controller for a common-anode multi-digit seven-segment display: rotates
// through a frame of hex digits, committing new frames only at frame boundaries.
// Optional leading-zero suppression: define SEG_SCAN_LZ_SUPPRESS_EN.
module seg_scan_ctrl #(
    parameter int NUM_DIGITS   = 4,
    parameter int ON_CYCLES    = 50000,
    parameter int GUARD_CYCLES = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load_valid,
    output logic                    load_ready,
    input  logic [4*NUM_DIGITS-1:0] load_data,
    input  logic [NUM_DIGITS-1:0]   blank_mask,
    output logic [3:0]              nibble_out,
    output logic [NUM_DIGITS-1:0]   digit_en,
    output logic                    frame_start
);
    localparam int MAXC = (ON_CYCLES > GUARD_CYCLES) ? ON_CYCLES : GUARD_CYCLES;
    localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
    localparam int IW   = $clog2(NUM_DIGITS);

    localparam logic [CW-1:0] ON_LAST    = CW'(ON_CYCLES - 1);
    localparam logic [CW-1:0] GUARD_LAST = CW'(GUARD_CYCLES - 1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

    typedef enum logic {S_GUARD, S_ON} state_t;

    state_t                  state, state_d;
    logic [CW-1:0]           cnt, cnt_d;
    logic [IW-1:0]           idx, idx_d;
    logic                    boundary;

    logic [4*NUM_DIGITS-1:0] display, pend;
    logic                    pending;
    logic [3:0]              cur_digit;
    logic                    dark;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_GUARD;
            cnt   <= '0;
            idx   <= '0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
            idx   <= idx_d;
        end
    end

    always_comb begin
        state_d  = state;
        cnt_d    = cnt + 1'b1;
        idx_d    = idx;
        boundary = 1'b0;
        case (state)
            S_GUARD: begin
                if (cnt == GUARD_LAST) begin
                    state_d = S_ON;
                    cnt_d   = '0;
                end
            end
            S_ON: begin
                if (cnt == ON_LAST) begin
                    state_d = S_GUARD;
                    cnt_d   = '0;
                    if (idx == IDX_LAST) begin
                        idx_d    = '0;
                        boundary = 1'b1;
                    end else begin
                        idx_d = idx + 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_GUARD;
                cnt_d   = '0;
            end
        endcase
    end

    // A transfer can only happen while nothing is pending, so a transfer that
    // lands on a boundary is naturally deferred to the following boundary.
    always_ff @(posedge clk) begin
        if (rst) begin
            display <= '0;
            pend    <= '0;
            pending <= 1'b0;
        end else if (boundary && pending) begin
            display <= pend;
            pending <= 1'b0;
        end else if (load_valid && !pending) begin
            pend    <= load_data;
            pending <= 1'b1;
        end
    end

    assign load_ready = ~pending;
    assign cur_digit  = display[{idx, 2'b00} +: 4];

`ifdef SEG_SCAN_LZ_SUPPRESS_EN
    // lz[i]: digit i and every digit above it are zero; digit 0 always lights.
    logic [NUM_DIGITS-1:0] lz;
    assign lz[0] = 1'b0;
    for (genvar g = 1; g < NUM_DIGITS; g++) begin : g_lz
        if (g == NUM_DIGITS - 1) begin : g_top
            assign lz[g] = (display[4*g +: 4] == 4'h0);
        end else begin : g_mid
            assign lz[g] = (display[4*g +: 4] == 4'h0) && lz[g+1];
        end
    end
    assign dark = blank_mask[idx] | lz[idx];
`else
    assign dark = blank_mask[idx];
`endif

    // Outputs are registered from the current state so digit_en and
    // nibble_out always move on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            digit_en    <= '0;
            nibble_out  <= '0;
            frame_start <= 1'b0;
        end else begin
            digit_en    <= '0;
            nibble_out  <= '0;
            frame_start <= (state == S_GUARD) && (idx == '0) && (cnt == '0);
            if (state == S_ON) begin
                nibble_out <= cur_digit;
                if (!dark)
                    digit_en <= NUM_DIGITS'(1) << idx;
            end
        end
    end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Self-checking bench for seg_scan_ctrl (4 digits, 4 on cycles, 1 guard cycle):
// expected scan frames are queued and compared cycle by cycle on the falling edge.
module tb_seg_scan_ctrl;
    localparam int N     = 4;
    localparam int FRAME = 20;

    logic        clk = 1'b0;
    logic        rst;
    logic        load_valid;
    logic        load_ready;
    logic [15:0] load_data;
    logic [3:0]  blank_mask;
    logic [3:0]  nibble_out;
    logic [3:0]  digit_en;
    logic        frame_start;

    int passed = 0;
    int total  = 0;
    int cyc    = 0;

    typedef struct packed {
        logic [3:0] en;
        logic [3:0] nib;
        logic       fs;
    } obs_t;

    obs_t sb[$];

    seg_scan_ctrl #(.NUM_DIGITS(N), .ON_CYCLES(4), .GUARD_CYCLES(1)) dut (
        .clk(clk), .rst(rst), .load_valid(load_valid), .load_ready(load_ready),
        .load_data(load_data), .blank_mask(blank_mask), .nibble_out(nibble_out),
        .digit_en(digit_en), .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            obs_t e;
            e = sb.pop_front();
            total++;
            if ({digit_en, nibble_out, frame_start} !== e)
                $display("FAIL scan cyc=%0d got en=%b nib=%h fs=%b want en=%b nib=%h fs=%b",
                         cyc, digit_en, nibble_out, frame_start, e.en, e.nib, e.fs);
            else
                passed++;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    function automatic logic lz_dark(input logic [15:0] d, input int i);
`ifdef SEG_SCAN_LZ_SUPPRESS_EN
        return (i > 0) && ((d >> (4 * i)) == 16'h0);
`else
        return 1'b0;
`endif
    endfunction

    // One frame: per digit, a dark guard cycle then four ON cycles.
    task automatic push_frame(input logic [15:0] disp, input logic [3:0] mask);
        obs_t e;
        for (int d = 0; d < N; d++) begin
            e.en  = 4'b0000;
            e.nib = 4'h0;
            e.fs  = (d == 0);
            sb.push_back(e);
            for (int k = 0; k < 4; k++) begin
                e.en  = (mask[d] || lz_dark(disp, d)) ? 4'b0000 : (4'b0001 << d);
                e.nib = disp[4*d +: 4];
                e.fs  = 1'b0;
                sb.push_back(e);
            end
        end
    endtask

    task automatic goto_frame_start();
        for (int i = 0; i < 2 * FRAME && (cyc % FRAME) != 1; i++) step();
    endtask

    task automatic goto_pos(input int p);
        for (int i = 0; i < 2 * FRAME && (cyc % FRAME) != p; i++) step();
    endtask

    task automatic test_reset();
        rst = 1'b1; load_valid = 1'b0; load_data = 16'h0; blank_mask = 4'b0;
        repeat (3) step();
        total++; if (digit_en !== 4'b0)  $display("FAIL rst_en got %b want 0000", digit_en);  else passed++;
        total++; if (nibble_out !== 4'h0) $display("FAIL rst_nib got %h want 0", nibble_out); else passed++;
        total++; if (frame_start !== 1'b0) $display("FAIL rst_fs got %b want 0", frame_start); else passed++;
        total++; if (load_ready !== 1'b1) $display("FAIL rst_ready got %b want 1", load_ready); else passed++;
        rst = 1'b0;
        cyc = 0;
        step();
        total++; if (frame_start !== 1'b1) $display("FAIL first_fs got %b want 1", frame_start); else passed++;
        push_frame(16'h0000, 4'b0000);
        goto_pos(0);
        step();
        total++; if (frame_start !== 1'b1) $display("FAIL period_fs got %b want 1", frame_start); else passed++;
    endtask

    task automatic test_load_commit();
        goto_frame_start();
        push_frame(16'h0000, 4'b0000);
        goto_pos(4);
        total++; if (load_ready !== 1'b1) $display("FAIL ready_before got %b want 1", load_ready); else passed++;
        load_data = 16'h1234; load_valid = 1'b1;
        step();
        load_valid = 1'b0; load_data = 16'h0;
        total++; if (load_ready !== 1'b0) $display("FAIL ready_drop got %b want 0", load_ready); else passed++;
        goto_pos(19);
        total++; if (load_ready !== 1'b0) $display("FAIL ready_hold got %b want 0", load_ready); else passed++;
        step();
        total++; if (load_ready !== 1'b1) $display("FAIL ready_return got %b want 1", load_ready); else passed++;
        goto_frame_start();
        push_frame(16'h1234, 4'b0000);
        goto_pos(0);
    endtask

    task automatic test_back_to_back();
        goto_frame_start();
        push_frame(16'h1234, 4'b0000);
        goto_pos(3);
        load_data = 16'hAAAA; load_valid = 1'b1;
        step();
        total++; if (load_ready !== 1'b0) $display("FAIL bp_ready got %b want 0", load_ready); else passed++;
        load_data = 16'hBBBB;
        goto_pos(0);
        load_valid = 1'b0;
        total++; if (load_ready !== 1'b1) $display("FAIL bp_ready_ret got %b want 1", load_ready); else passed++;
        for (int f = 0; f < 2; f++) begin
            goto_frame_start();
            push_frame(16'hAAAA, 4'b0000);
            goto_pos(0);
        end
        total++; if (load_ready !== 1'b1) $display("FAIL bp_ready_end got %b want 1", load_ready); else passed++;
    endtask

    task automatic test_blanking();
        goto_frame_start();
        push_frame(16'hAAAA, 4'b0000);
        goto_pos(5);
        load_data = 16'h5678; load_valid = 1'b1;
        step();
        load_valid = 1'b0;
        goto_pos(0);
        blank_mask = 4'b0100;
        goto_frame_start();
        push_frame(16'h5678, 4'b0100);
        goto_pos(0);
        blank_mask = 4'b0000;
        goto_frame_start();
        push_frame(16'h5678, 4'b0000);
        goto_pos(0);
    endtask

    task automatic test_reset_midframe();
        goto_frame_start();
        push_frame(16'h5678, 4'b0000);
        goto_pos(3);
        load_data = 16'h9ABC; load_valid = 1'b1;
        step();
        load_valid = 1'b0;
        total++; if (load_ready !== 1'b0) $display("FAIL mid_pend got %b want 0", load_ready); else passed++;
        goto_pos(12);
        rst = 1'b1;
        sb.delete();
        step();
        total++; if (digit_en !== 4'b0)   $display("FAIL mid_en got %b want 0000", digit_en);   else passed++;
        total++; if (load_ready !== 1'b1) $display("FAIL mid_ready got %b want 1", load_ready); else passed++;
        total++; if (nibble_out !== 4'h0) $display("FAIL mid_nib got %h want 0", nibble_out);  else passed++;
        rst = 1'b0;
        cyc = 0;
        step();
        push_frame(16'h0000, 4'b0000);
        goto_pos(0);
        goto_frame_start();
        push_frame(16'h0000, 4'b0000);
        goto_pos(0);
    endtask

    task automatic test_lz();
        goto_frame_start();
        push_frame(16'h0000, 4'b0000);
        goto_pos(4);
        load_data = 16'h0040; load_valid = 1'b1;
        step();
        load_valid = 1'b0;
        goto_pos(0);
        goto_frame_start();
        push_frame(16'h0040, 4'b0000);
        goto_pos(0);
    endtask

    initial begin
        test_reset();
        test_load_commit();
        test_back_to_back();
        test_blanking();
        test_reset_midframe();
        test_lz();
        repeat (2) step();
        total++; if (sb.size() != 0) $display("FAIL sb_drain left=%0d want 0", sb.size()); else passed++;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
